// File: rtl/alu_issue_ctrl.sv
// Issue/collect stage around a one-cycle registered 8-bit ALU: credit-based command
// issue, in-order result FIFO, and optional accumulator chaining of the last result.
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_sel,
    input  logic       cmd_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic          issue_v_q, issue_v_d;
    logic          alu_v_q, alu_v_d;
    logic [7:0]    last_res_q, last_res_d;
    logic [8:0]    mem_q [DEPTH];
    logic [8:0]    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]    inflight;
    logic [CW:0]   occupancy;
    logic          credit_ok;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        inflight   = {1'b0, issue_v_q} + {1'b0, alu_v_q};
        // Occupancy uses registered state only, so a pop frees its credit one cycle later.
        occupancy  = {1'b0, count_q} + {{(CW - 1){1'b0}}, inflight};
        credit_ok  = occupancy < DEPTH_W;
        cmd_ready  = credit_ok && !(cmd_chain && (inflight != 2'd0));
        accept     = cmd_valid && cmd_ready;
        push       = alu_v_q;
        pop        = (count_q != '0) && res_ready;

        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        issue_v_d  = accept;
        alu_v_d    = issue_v_q;
        last_res_d = last_res_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            alu_a_d   = cmd_chain ? last_res_q : cmd_a;
            alu_b_d   = cmd_b;
            alu_sel_d = cmd_sel;
        end

        if (push) begin
            mem_d[wr_ptr_q] = {alu_carry, alu_out};
            wr_ptr_d        = wr_ptr_q + PW'(1);
            last_res_d      = alu_out;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            issue_v_q  <= 1'b0;
            alu_v_q    <= 1'b0;
            last_res_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            issue_v_q  <= issue_v_d;
            alu_v_q    <= alu_v_d;
            last_res_q <= last_res_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = (count_q != '0);
    assign res_data  = mem_q[rd_ptr_q][7:0];
    assign res_carry = mem_q[rd_ptr_q][8];
    assign busy      = issue_v_q | alu_v_q | (count_q != '0);

    // Credit accounting must keep the FIFO from ever exceeding its depth.
    assert property (@(posedge clk) disable iff (reset) ({1'b0, count_q} <= DEPTH_W));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: emulates the registered ALU and checks every cycle
// against a transaction-level model (queue of accepted-but-unpopped results).
module tb_alu_issue_ctrl;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_chain;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;
    int n_pop = 0;
    int last_acc_cyc = 0;
    int last_pop_cyc = 0;

    logic [8:0] exp_q [$];
    int         avail_q [$];
    logic [8:0] pop_log [$];
    logic [7:0] model_last = 8'h00;

    logic [7:0] bp_a   [6] = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] bp_b   [6] = '{8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [2:0] bp_sel [6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b100, 3'b000};

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {carry, result} for the ALU opcodes.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {1'b0, a & b};
            3'b011:  return {1'b0, a | b};
            3'b100:  return {1'b0, a ^ b};
            3'b101:  return {1'b0, ~(a | b)};
            3'b110:  return {a[7], a[6:0], 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        {alu_carry, alu_out} <= alu_f(alu_a, alu_b, alu_sel);
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic ch);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        cmd_chain = ch;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    endtask

    // One clock: called just after a falling edge with inputs set; checks the DUT
    // against the model, applies the handshakes to the model, then waits a full clock.
    task automatic cycle();
        int   inpipe;
        logic exp_ready;
        logic exp_rv;
        logic exp_busy;
        logic [7:0] a_eff;
        logic [8:0] r;
        #1;
        inpipe = 0;
        foreach (avail_q[i]) if (avail_q[i] > cyc) inpipe++;
        exp_ready = (exp_q.size() < DEPTH) && !(cmd_chain && inpipe != 0);
        exp_rv    = (exp_q.size() != 0) && (avail_q[0] <= cyc);
        exp_busy  = (exp_q.size() != 0);
        total++;
        if (cmd_ready !== exp_ready) begin
            bad++;
            $display("FAIL cmd_ready cyc=%0d got=%b want=%b", cyc, cmd_ready, exp_ready);
        end
        total++;
        if (res_valid !== exp_rv) begin
            bad++;
            $display("FAIL res_valid cyc=%0d got=%b want=%b", cyc, res_valid, exp_rv);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
        end
        if (res_valid === 1'b1 && res_ready === 1'b1 && exp_q.size() != 0) begin
            total++;
            if ({res_carry, res_data} !== exp_q[0]) begin
                bad++;
                $display("FAIL res_data cyc=%0d got=%h want=%h", cyc, {res_carry, res_data}, exp_q[0]);
            end
            pop_log.push_back({res_carry, res_data});
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
            n_pop++;
            last_pop_cyc = cyc;
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            a_eff = cmd_chain ? model_last : cmd_a;
            r = alu_f(a_eff, cmd_b, cmd_sel);
            exp_q.push_back(r);
            // Accept edge ends this cycle; two more edges put it in the FIFO.
            avail_q.push_back(cyc + 3);
            model_last = r[7:0];
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic ch);
        int a0;
        bit done;
        done = 0;
        drive(1'b1, a, b, s, ch);
        for (int k = 0; k < 20 && !done; k++) begin
            a0 = acc_cnt;
            cycle();
            if (acc_cnt != a0) done = 1;
        end
        idle();
        if (!done) begin
            total++;
            bad++;
            $display("FAIL issue_timeout got=no_accept want=accept");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) cycle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d_left want=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        total++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'b000) begin
            bad++;
            $display("FAIL reset_alu got=%h/%h/%h want=0/0/0", alu_a, alu_b, alu_sel);
        end
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got=rv%b_busy%b want=rv0_busy0", res_valid, busy);
        end
        reset = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", cmd_ready);
        end
    endtask

    task automatic test_add();
        res_ready = 1'b1;
        pop_log.delete();
        issue(8'h80, 8'h90, 3'b000, 1'b0);
        drain();
        total++;
        if (pop_log.size() != 1 || pop_log[0] !== 9'h110) begin
            bad++;
            $display("FAIL add_result got=%h want=110", (pop_log.size() != 0) ? pop_log[0] : 9'h0);
        end
        total++;
        if (last_pop_cyc - last_acc_cyc != 3) begin
            bad++;
            $display("FAIL add_latency got=%0d want=3", last_pop_cyc - last_acc_cyc);
        end
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL add_busy_drop got=%b want=0", busy);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        int a0;
        int acc0;
        int pop0;
        idx = 0;
        acc0 = acc_cnt;
        pop0 = n_pop;
        res_ready = 1'b0;
        pop_log.delete();
        for (int k = 0; k < 10; k++) begin
            if (idx < 6) drive(1'b1, bp_a[idx], bp_b[idx], bp_sel[idx], 1'b0);
            else idle();
            a0 = acc_cnt;
            cycle();
            if (acc_cnt != a0) idx++;
        end
        total++;
        if (acc_cnt - acc0 != DEPTH) begin
            bad++;
            $display("FAIL bp_accepted got=%0d want=%0d", acc_cnt - acc0, DEPTH);
        end
        #1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_low got=%b want=0", cmd_ready);
        end
        res_ready = 1'b1;
        for (int k = 0; k < 60 && (idx < 6 || exp_q.size() != 0); k++) begin
            if (idx < 6) drive(1'b1, bp_a[idx], bp_b[idx], bp_sel[idx], 1'b0);
            else idle();
            a0 = acc_cnt;
            cycle();
            if (acc_cnt != a0) idx++;
        end
        idle();
        total++;
        if (n_pop - pop0 != 6) begin
            bad++;
            $display("FAIL bp_popped got=%0d want=6", n_pop - pop0);
        end
        total++;
        if (pop_log.size() == 0 || pop_log[0] !== 9'h1FE) begin
            bad++;
            $display("FAIL bp_first got=%h want=1fe", (pop_log.size() != 0) ? pop_log[0] : 9'h0);
        end
    endtask

    task automatic test_chain();
        int stalls;
        int a0;
        bit done;
        stalls = 0;
        done = 0;
        res_ready = 1'b1;
        pop_log.delete();
        issue(8'h01, 8'h02, 3'b000, 1'b0);
        drive(1'b1, 8'hAA, 8'h04, 3'b000, 1'b1);
        for (int k = 0; k < 10 && !done; k++) begin
            a0 = acc_cnt;
            cycle();
            if (acc_cnt != a0) done = 1;
            else stalls++;
        end
        idle();
        drain();
        total++;
        if (stalls != 2) begin
            bad++;
            $display("FAIL chain_stall got=%0d want=2", stalls);
        end
        total++;
        if (pop_log.size() != 2 || pop_log[1] !== 9'h007) begin
            bad++;
            $display("FAIL chain_result got=%h want=007", (pop_log.size() > 1) ? pop_log[1] : 9'h0);
        end
    endtask

    task automatic test_stream();
        int issued;
        int a0;
        int pop0;
        issued = 0;
        pop0 = n_pop;
        for (int k = 0; k < 300 && (issued < 3 * DEPTH || exp_q.size() != 0); k++) begin
            if (issued < 3 * DEPTH)
                drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0));
            else idle();
            res_ready = k[0];
            a0 = acc_cnt;
            cycle();
            if (acc_cnt != a0) issued++;
        end
        idle();
        total++;
        if (n_pop - pop0 != 3 * DEPTH) begin
            bad++;
            $display("FAIL stream_count got=%0d want=%0d", n_pop - pop0, 3 * DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        pop_log.delete();
        issue(8'h10, 8'h01, 3'b000, 1'b0);
        issue(8'h20, 8'h02, 3'b000, 1'b0);
        issue(8'h30, 8'h03, 3'b000, 1'b0);
        total++;
        if (!(res_valid === 1'b1 && dut.issue_v_q === 1'b1 && dut.alu_v_q === 1'b1)) begin
            bad++;
            $display("FAIL rstmid_setup got=rv%b_iv%b_av%b want=rv1_iv1_av1",
                     res_valid, dut.issue_v_q, dut.alu_v_q);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_status got=rv%b_busy%b want=rv0_busy0", res_valid, busy);
        end
        total++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 3'b000) begin
            bad++;
            $display("FAIL rstmid_alu got=%h/%h/%h want=0/0/0", alu_a, alu_b, alu_sel);
        end
        exp_q.delete();
        avail_q.delete();
        model_last = 8'h00;
        @(negedge clk);
        cyc++;
        #2;
        reset = 1'b0;
        @(negedge clk);
        cyc++;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b want=1", cmd_ready);
        end
        res_ready = 1'b1;
        issue(8'h33, 8'h05, 3'b000, 1'b1);
        drain();
        total++;
        if (pop_log.size() == 0 || pop_log[pop_log.size() - 1] !== 9'h005) begin
            bad++;
            $display("FAIL rstmid_chain got=%h want=005",
                     (pop_log.size() != 0) ? pop_log[pop_log.size() - 1] : 9'h0);
        end
    endtask

    task automatic test_shifts();
        res_ready = 1'b1;
        pop_log.delete();
        issue(8'h81, 8'h00, 3'b110, 1'b0);
        issue(8'h81, 8'h00, 3'b111, 1'b0);
        issue(8'h0F, 8'hF0, 3'b101, 1'b0);
        drain();
        total++;
        if (pop_log.size() != 3) begin
            bad++;
            $display("FAIL shift_count got=%0d want=3", pop_log.size());
        end else begin
            total++;
            if (pop_log[0] !== 9'h102) begin
                bad++;
                $display("FAIL shl got=%h want=102", pop_log[0]);
            end
            total++;
            if (pop_log[1] !== 9'h140) begin
                bad++;
                $display("FAIL shr got=%h want=140", pop_log[1]);
            end
            total++;
            if (pop_log[2] !== 9'h000) begin
                bad++;
                $display("FAIL nor got=%h want=000", pop_log[2]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        res_ready = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_add();
        test_backpressure();
        test_chain();
        test_stream();
        test_reset_mid();
        test_shifts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
